// File: rtl/cpu_paddle_ctrl_if.sv
// Signal bundle between the ball/paddle datapath and the CPU paddle controller.
// master = datapath side driving observations; slave = controller issuing steps.
interface cpu_paddle_ctrl_if;
  logic       enable;
  logic [9:0] ball_y;
  logic       ball_toward;
  logic [9:0] racket_y;
  logic       up;
  logic       down;
  logic [2:0] state;

  modport master (
    output enable, ball_y, ball_toward, racket_y,
    input  up, down, state
  );

  modport slave (
    input  enable, ball_y, ball_toward, racket_y,
    output up, down, state
  );
endinterface

// File: rtl/cpu_paddle_ctrl.sv
// Beatable CPU opponent: reaction delay, dead zone, rate-limited steps, return-to-centre.
// Optional target jitter from an LFSR when CPU_PADDLE_JITTER_EN is defined.
module cpu_paddle_ctrl #(
  parameter int RACKET_H  = 40,
  parameter int Y_MAX     = 440,
  parameter int CENTER_Y  = 200,
  parameter int DEAD_ZONE = 4,
  parameter int STEP_DIV  = 2,
  parameter int REACT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  cpu_paddle_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_TRACK  = 3'd2;
  localparam logic [2:0] S_RETURN = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam int DIV_W   = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int REACT_W = (REACT_CYC > 1) ? $clog2(REACT_CYC) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [REACT_W-1:0] REACT_LAST = REACT_W'(REACT_CYC - 1);

  localparam logic signed [10:0] HALF_H   = 11'(RACKET_H / 2);
  localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
  localparam logic signed [10:0] CENTER_S = 11'(CENTER_Y);
  localparam logic signed [10:0] DZ_S     = 11'(DEAD_ZONE);

  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [REACT_W-1:0] react_q, react_d;
  logic               up_q, up_d;
  logic               down_q, down_d;

  logic               tick;
  logic               idle_q;
  logic               near;
  logic signed [10:0] offset;
  logic signed [10:0] target_raw;
  logic signed [10:0] target;
  logic signed [10:0] err;

`ifdef CPU_PADDLE_JITTER_EN
  logic [7:0]         lfsr_q, lfsr_d;
  logic signed [10:0] offset_q, offset_d;

  // Offset is captured only when tracking begins, so it stays fixed for one rally.
  always_comb begin
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    offset_d = offset_q;
    if (state_q == S_WAIT && state_d == S_TRACK) begin
      offset_d = $signed({6'b0, lfsr_q[4:0]}) - 11'sd16;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q   <= 8'hA5;
      offset_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      offset_q <= offset_d;
    end
  end

  assign offset = offset_q;
`else
  assign offset = '0;
`endif

  // Encodings 5..7 behave exactly like IDLE.
  assign idle_q = (state_q == S_IDLE) || (state_q > S_HOLD);
  assign tick   = (div_q == DIV_LAST);

  always_comb begin
    target_raw = $signed({1'b0, bus.ball_y}) - HALF_H + offset;
    target     = CENTER_S;
    if (state_q == S_TRACK) begin
      if (target_raw < 11'sd0) begin
        target = 11'sd0;
      end else if (target_raw > YMAX_S) begin
        target = YMAX_S;
      end else begin
        target = target_raw;
      end
    end
    err  = target - $signed({1'b0, bus.racket_y});
    near = (err <= DZ_S) && (err >= -DZ_S);
  end

  // State, divider and reaction counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      react_q <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      react_q <= react_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  // Next-state logic. A falling ball_toward in WAIT beats the reaction expiry.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (!bus.ball_toward) begin
            state_d = S_RETURN;
          end else if (react_q == REACT_LAST) begin
            state_d = S_TRACK;
          end
        end
        S_TRACK: begin
          if (!bus.ball_toward) begin
            state_d = S_RETURN;
          end
        end
        S_RETURN: begin
          if (bus.ball_toward) begin
            state_d = S_WAIT;
          end else if (near) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.ball_toward) begin
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = bus.ball_toward ? S_WAIT : S_RETURN;
        end
      endcase
    end
  end

  always_comb begin
    div_d = '0;
    if (!idle_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    react_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      react_d = react_q + 1'b1;
    end
  end

  // Steps only when both this cycle and the next are moving states, so a pulse
  // never coincides with WAIT/HOLD/IDLE on the state output.
  always_comb begin
    logic moving;
    moving = tick
           && (state_q == S_TRACK || state_q == S_RETURN)
           && (state_d == S_TRACK || state_d == S_RETURN);
    down_d = moving && (err > DZ_S) && (bus.racket_y < 10'(Y_MAX));
    up_d   = moving && (err < -DZ_S) && (bus.racket_y != 10'd0);
  end

  assign bus.up    = up_q;
  assign bus.down  = down_q;
  assign bus.state = state_q;

endmodule
